aont_chaff_serializer: RTL and testbench
========================================

Name: aont_chaff_serializer

Overview:
- Downstream stage of the AONT transform in the chaffing-and-winnowing datapath.
- Accepts one transformed frame of noofblocks x lslen symbols, each lslenlog bits wide, over a valid/ready handshake.
- Serializes the frame into per-symbol packets. Each symbol produces one wheat packet (true data, keyed tag) and one chaff packet (complemented data, corrupted tag).
- Wheat/chaff order within each pair is scrambled by an internal LFSR, so the receiver can only winnow using the key.

Parameters:
- noofblocks, 9, AONT blocks per frame (8 message blocks + 1 key block).
- lslen, 16, symbols per block.
- lslenlog, 4, bits per symbol.
- TAGW, 16, tag width in bits.
- SEQW, 8, sequence-number width; must satisfy 2^SEQW >= noofblocks*lslen.
- LFSR_SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'h0001.

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  synchronous active-low reset.
- in_valid  input  1  frame valid.
- in_ready  output  1  frame accepted when in_valid && in_ready.
- in_frame  input  noofblocks*lslen*lslenlog  frame; symbol k = in_frame[k*lslenlog +: lslenlog], with k = block*lslen + j.
- key  input  TAGW  tag key, sampled with the frame.
- out_valid  output  1  packet valid.
- out_ready  input  1  downstream accepts packet.
- out_seq  output  SEQW  symbol index k.
- out_data  output  lslenlog  packet symbol.
- out_tag  output  TAGW  packet tag.
- out_wheat  output  1  1 = wheat, 0 = chaff (debug/verification only; not transmitted).
- out_last  output  1  final packet of frame.

Behaviour:
- Reset (rstn=0 at posedge):
  - FSM goes to IDLE; frame register, key register and symbol index cleared.
  - LFSR loads LFSR_SEED.
  - in_ready=1; out_valid=0; out_seq, out_data, out_tag, out_wheat, out_last = 0.
  - Reset mid-frame discards the remainder of the frame; no further packets are emitted.
- FSM states: IDLE, FIRST, SECOND.
  - IDLE: in_ready=1. On in_valid, capture in_frame and key, set k=0, go to FIRST. out_valid rises the next cycle (latency 1).
  - FIRST: present the first packet of pair k. On out_ready, go to SECOND.
  - SECOND: present the second packet of pair k. On out_ready:
    - Step the LFSR once.
    - If k == noofblocks*lslen-1, go to IDLE (in_ready=1 in the following cycle).
    - Otherwise k=k+1 and go to FIRST.
  - in_ready=0 in FIRST and SECOND. Frames offered then are not accepted, and in_frame is not sampled.
- Pair contents for symbol d = symbol k, both packets carrying out_seq = k:
  - Wheat: data = d; tag_w = (key ^ zero-extended k) + zero-extended d, mod 2^TAGW.
  - Chaff: data = ~d (always differs from wheat); tag_c = tag_w ^ (lfsr | 1), truncated/extended to TAGW, never equal to tag_w.
  - If lfsr[0]=1, chaff is presented first; otherwise wheat is first. lfsr[0] is the LFSR value at pair start and is held for both packets of the pair.
- LFSR:
  - 16-bit Galois, right shift: next = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0).
  - Steps only on acceptance of a pair's second packet; it is not restarted between frames.
- Output handshake:
  - All outputs are registered.
  - While out_valid=1 && out_ready=0, every out_* signal holds stable.
  - With out_ready held high, one packet is emitted per cycle, so a frame takes 2*noofblocks*lslen cycles (288 at defaults).
- out_last = 1 only on the second packet of the final pair. out_wheat reflects the packet type.
- Key change while busy has no effect; the key registered at acceptance is used.

Test Plan:
- Reset, key=16'h00A5, symbol0=4'h3, out_ready=1 -> packet 0: seq=0, chaff, data=C, tag=16'hAC49; packet 1: seq=0, wheat, data=3, tag=16'h00A8.
- Continue the same frame, symbol1=4'h7 -> LFSR=16'hE270 (lfsr[0]=0) so wheat is first: seq=1, data=7, tag=(00A5^0001)+7=16'h00AB; then chaff: data=8, tag=16'h00AB^16'hE271=16'hE2DA.
- Default-parameter frame with out_ready=1 -> exactly 288 packets; out_last only on packet 287 (seq=143); in_ready returns 1 on the cycle after its acceptance.
- out_ready toggled randomly, including a 5-cycle stall on packet 10 -> outputs stable during the stall; packet sequence identical to the no-stall run.
- in_valid asserted with a second frame while busy -> not accepted until IDLE; then served, with the LFSR continuing rather than reseeded.
- rstn=0 for one cycle at packet 50 -> next cycle out_valid=0, in_ready=1; a new frame restarts at seq=0 with LFSR=16'hACE1.

Source files
------------

// File: rtl/aont_chaff_serializer.sv
// AONT chaff serializer: turns one accepted frame into wheat/chaff packet pairs,
// one pair per symbol, with the order inside each pair picked by an LFSR bit.
//
// state  | meaning
// IDLE   | waiting for a frame, in_ready high
// FIRST  | presenting the first packet of pair k
// SECOND | presenting the second packet of pair k
module aont_chaff_serializer #(
    parameter int          noofblocks = 9,
    parameter int          lslen      = 16,
    parameter int          lslenlog   = 4,
    parameter int          TAGW       = 16,
    parameter int          SEQW       = 8,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [noofblocks*lslen*lslenlog-1:0]   in_frame,
    input  logic [TAGW-1:0]                        key,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [SEQW-1:0]                        out_seq,
    output logic [lslenlog-1:0]                    out_data,
    output logic [TAGW-1:0]                        out_tag,
    output logic                                   out_wheat,
    output logic                                   out_last
);

    localparam int              NSYM   = noofblocks * lslen;
    localparam int              FRAMEW = NSYM * lslenlog;
    localparam int              IDXW   = $clog2(FRAMEW);
    localparam logic [SEQW-1:0] K_LAST = SEQW'(NSYM - 1);
    // An all-zero Galois LFSR never leaves zero, so a zero seed is remapped.
    localparam logic [15:0]     SEED   = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    typedef enum logic [1:0] {IDLE, FIRST, SECOND} state_t;

    state_t              state_q, state_d;
    logic [FRAMEW-1:0]   frame_q, frame_d;
    logic [TAGW-1:0]     key_q, key_d;
    logic [SEQW-1:0]     k_q, k_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [15:0]         lfsr_step;

    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [SEQW-1:0]     out_seq_q, out_seq_d;
    logic [lslenlog-1:0] out_data_q, out_data_d;
    logic [TAGW-1:0]     out_tag_q, out_tag_d;
    logic                out_wheat_q, out_wheat_d;
    logic                out_last_q, out_last_d;

    logic [IDXW-1:0]     sym_base;
    logic [lslenlog-1:0] sym;
    logic [TAGW-1:0]     tag_w, tag_c;
    logic                is_wheat;

    assign lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    // Next-state logic: frame capture, pair sequencing and LFSR stepping.
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        key_d   = key_q;
        k_d     = k_q;
        lfsr_d  = lfsr_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    frame_d = in_frame;
                    key_d   = key;
                    k_d     = '0;
                    state_d = FIRST;
                end
            end
            FIRST: begin
                if (out_ready) state_d = SECOND;
            end
            SECOND: begin
                if (out_ready) begin
                    lfsr_d = lfsr_step;
                    if (k_q == K_LAST) begin
                        state_d = IDLE;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = FIRST;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Packet contents are computed from next-state values so every output is a flop.
    always_comb begin
        sym_base    = IDXW'(k_d) * IDXW'(lslenlog);
        sym         = frame_d[sym_base +: lslenlog];
        tag_w       = (key_d ^ TAGW'(k_d)) + TAGW'(sym);
        tag_c       = tag_w ^ TAGW'(lfsr_d | 16'h0001);
        // lfsr_d[0] is the pair-start bit; it only changes when leaving SECOND.
        is_wheat    = (state_d == FIRST) ? ~lfsr_d[0] : lfsr_d[0];
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        out_seq_d   = '0;
        out_data_d  = '0;
        out_tag_d   = '0;
        out_wheat_d = 1'b0;
        out_last_d  = 1'b0;
        if (state_d == IDLE) begin
            in_ready_d = 1'b1;
        end else begin
            out_valid_d = 1'b1;
            out_seq_d   = k_d;
            out_data_d  = is_wheat ? sym : ~sym;
            out_tag_d   = is_wheat ? tag_w : tag_c;
            out_wheat_d = is_wheat;
            out_last_d  = (state_d == SECOND) && (k_d == K_LAST);
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            frame_q     <= '0;
            key_q       <= '0;
            k_q         <= '0;
            lfsr_q      <= SEED;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_seq_q   <= '0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            out_wheat_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            key_q       <= key_d;
            k_q         <= k_d;
            lfsr_q      <= lfsr_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_seq_q   <= out_seq_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            out_wheat_q <= out_wheat_d;
            out_last_q  <= out_last_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_seq   = out_seq_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;
    assign out_wheat = out_wheat_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_aont_chaff_serializer.sv
// Scoreboard bench for aont_chaff_serializer at default parameters.
module tb_aont_chaff_serializer;

    localparam int NSYM = 144;
    localparam int FW   = 576;

    logic          clk = 1'b0;
    logic          rstn;
    logic          in_valid;
    logic          in_ready;
    logic [FW-1:0] in_frame;
    logic [15:0]   key;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_seq;
    logic [3:0]    out_data;
    logic [15:0]   out_tag;
    logic          out_wheat;
    logic          out_last;

    always #5 clk = ~clk;

    aont_chaff_serializer dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_frame  (in_frame),
        .key       (key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_seq   (out_seq),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_wheat (out_wheat),
        .out_last  (out_last)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [29:0] sb[$];
    logic [15:0] m_lfsr;
    bit          busy;
    int          pops;
    int          busy_cycles;
    bit          dir_en;
    logic [29:0] dir_exp [4];
    logic [FW-1:0] fa, fc, fd, fe;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected packet stream of a frame, from the key and the model LFSR.
    task automatic push_frame(input logic [FW-1:0] f, input logic [15:0] kk);
        logic [3:0]  d;
        logic [15:0] tw, tc;
        logic [7:0]  s;
        bit          lst;
        for (int k = 0; k < NSYM; k++) begin
            d   = f[k*4 +: 4];
            s   = 8'(k);
            tw  = (kk ^ {8'h00, s}) + {12'h000, d};
            tc  = tw ^ (m_lfsr | 16'h0001);
            lst = (k == NSYM - 1);
            if (m_lfsr[0]) begin
                sb.push_back({s, ~d, tc, 1'b0, 1'b0});
                sb.push_back({s, d, tw, 1'b1, lst});
            end else begin
                sb.push_back({s, d, tw, 1'b1, 1'b0});
                sb.push_back({s, ~d, tc, 1'b0, lst});
            end
            m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
        end
    endtask

    // Apply the current inputs across one rising edge, then check at the falling edge.
    task automatic tick();
        logic [29:0] p;
        bit          acc;
        if (!rstn) begin
            sb.delete();
            busy   = 0;
            m_lfsr = 16'hACE1;
        end else begin
            acc = in_valid && !busy;
            if (sb.size() > 0 && out_ready) begin
                p = sb.pop_front();
                pops++;
                if (p[0]) busy = 0;
            end
            if (acc) begin
                push_frame(in_frame, key);
                busy        = 1;
                pops        = 0;
                busy_cycles = 0;
            end
        end
        @(negedge clk);
        if (busy) busy_cycles++;
        chk("in_ready", in_ready, !busy);
        chk("out_valid", out_valid, sb.size() > 0);
        if (sb.size() > 0) begin
            chk("pkt", {out_seq, out_data, out_tag, out_wheat, out_last}, sb[0]);
            if (dir_en && pops < 4)
                chk("tp_pkt", {out_seq, out_data, out_tag, out_wheat, out_last}, dir_exp[pops]);
        end
    endtask

    task automatic run(input bit rnd);
        int guard = 0;
        int stall = 0;
        while (busy && guard < 5000) begin
            if (rnd && pops == 10 && stall < 5) begin
                out_ready = 1'b0;
                stall++;
            end else begin
                out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            key = 16'($urandom);
            tick();
            guard++;
        end
        chk("timeout", busy, 0);
    endtask

    task automatic rand_frame(output logic [FW-1:0] f);
        for (int i = 0; i < FW / 32; i++) f[i*32 +: 32] = $urandom;
    endtask

    initial begin
        dir_exp[0] = {8'd0, 4'hC, 16'hAC49, 1'b0, 1'b0};
        dir_exp[1] = {8'd0, 4'h3, 16'h00A8, 1'b1, 1'b0};
        dir_exp[2] = {8'd1, 4'h7, 16'h00AB, 1'b1, 1'b0};
        dir_exp[3] = {8'd1, 4'h8, 16'hE2DA, 1'b0, 1'b0};
        dir_en      = 0;
        busy        = 0;
        pops        = 0;
        busy_cycles = 0;
        m_lfsr      = 16'hACE1;
        rstn        = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        in_frame    = '0;
        key         = '0;
        @(negedge clk);
        tick();
        tick();
        chk("rst_outs", {out_valid, in_ready, out_seq, out_data, out_tag, out_wheat, out_last},
            {1'b0, 1'b1, 30'h0});
        rstn = 1'b1;

        // Frame A: directed first symbols, out_ready held high.
        rand_frame(fa);
        fa[3:0] = 4'h3;
        fa[7:4] = 4'h7;
        dir_en    = 1;
        in_valid  = 1'b1;
        in_frame  = fa;
        key       = 16'h00A5;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        run(0);
        dir_en = 0;
        chk("a_pops", pops, 288);
        chk("a_cycles", busy_cycles, 288);

        // Frame B: same frame after reset, random backpressure with a stall on packet 10,
        // while frame C is offered the whole time.
        rstn = 1'b0;
        tick();
        rstn     = 1'b1;
        dir_en   = 1;
        in_valid = 1'b1;
        in_frame = fa;
        key      = 16'h00A5;
        tick();
        rand_frame(fc);
        in_frame = fc;
        key      = 16'h3C5A;
        run(1);
        dir_en = 0;
        chk("b_pops", pops, 288);
        key = 16'h3C5A;
        tick();
        in_valid = 1'b0;
        chk("c_accept", busy, 1);
        run(1);
        chk("c_pops", pops, 288);

        // Frame D interrupted by reset at packet 50, then frame E from the seed.
        rand_frame(fd);
        in_valid  = 1'b1;
        in_frame  = fd;
        key       = 16'h1234;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int g = 0; g < 200 && pops < 50; g++) tick();
        chk("d_pops", pops, 50);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("midrst", {out_valid, in_ready}, 2'b01);
        rand_frame(fe);
        in_valid = 1'b1;
        in_frame = fe;
        key      = 16'hBEEF;
        tick();
        in_valid = 1'b0;
        chk("e_seq0", out_seq, 8'd0);
        run(1);
        chk("e_pops", pops, 288);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
